// File: rtl/core_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, ALU operations and
// the control half of the ID/EX pipeline register.
package core_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_SRA  = 6'h03,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A,
        F_SLTU = 6'h2B
    } funct_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    typedef struct packed {
        logic [4:0] shamt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        alu_op_t    alu_op;
        logic       alu_src_imm;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       beq;
        logic       bne;
        logic       illegal;
    } ctrl_t;

    // Data fields (pc/operands/imm) are XLEN-parameterised and live beside this.
    typedef struct packed {
        logic  valid;
        ctrl_t ctrl;
    } id_ex_t;

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational decode of the supported MIPS-I integer subset.
module instr_decoder
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic            rs_used_o,
    output logic            rt_used_o
);

    opcode_e     opcode;
    funct_e      funct;
    logic [15:0] imm16;

    assign opcode = opcode_e'(instr_i[31:26]);
    assign funct  = funct_e'(instr_i[5:0]);
    assign imm16  = instr_i[15:0];

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        ctrl_o       = '0;
        ctrl_o.rs    = instr_i[25:21];
        ctrl_o.rt    = instr_i[20:16];
        ctrl_o.shamt = instr_i[10:6];
        imm_o        = {{(XLEN-16){imm16[15]}}, imm16};
        rs_used_o    = 1'b1;
        rt_used_o    = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                ctrl_o.dest     = instr_i[15:11];
                ctrl_o.regwrite = 1'b1;
                rt_used_o       = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: ctrl_o.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: ctrl_o.alu_op = ALU_SUB;
                    F_AND:         ctrl_o.alu_op = ALU_AND;
                    F_OR:          ctrl_o.alu_op = ALU_OR;
                    F_XOR:         ctrl_o.alu_op = ALU_XOR;
                    F_NOR:         ctrl_o.alu_op = ALU_NOR;
                    F_SLT:         ctrl_o.alu_op = ALU_SLT;
                    F_SLTU:        ctrl_o.alu_op = ALU_SLTU;
                    F_SLL: begin ctrl_o.alu_op = ALU_SLL; rs_used_o = 1'b0; end
                    F_SRL: begin ctrl_o.alu_op = ALU_SRL; rs_used_o = 1'b0; end
                    F_SRA: begin ctrl_o.alu_op = ALU_SRA; rs_used_o = 1'b0; end
                    default:       ctrl_o.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                ctrl_o.dest        = instr_i[20:16];
                ctrl_o.regwrite    = 1'b1;
                ctrl_o.alu_src_imm = 1'b1;
                ctrl_o.memread     = (opcode == OP_LW);
                case (opcode)
                    OP_SLTI:  ctrl_o.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl_o.alu_op = ALU_SLTU;
                    OP_ANDI: begin ctrl_o.alu_op = ALU_AND; imm_o = XLEN'(imm16); end
                    OP_ORI:  begin ctrl_o.alu_op = ALU_OR;  imm_o = XLEN'(imm16); end
                    OP_XORI: begin ctrl_o.alu_op = ALU_XOR; imm_o = XLEN'(imm16); end
                    OP_LUI: begin
                        ctrl_o.alu_op = ALU_LUI;
                        imm_o         = XLEN'({imm16, 16'h0000});
                        rs_used_o     = 1'b0;
                    end
                    default:  ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                ctrl_o.alu_src_imm = 1'b1;
                ctrl_o.memwrite    = 1'b1;
                ctrl_o.alu_op      = ALU_ADD;
                rt_used_o          = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.alu_op = ALU_SUB;
                ctrl_o.beq    = (opcode == OP_BEQ);
                ctrl_o.bne    = (opcode == OP_BNE);
                rt_used_o     = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase

        // Illegal encodings must not write, access memory or trigger hazards.
        if (ctrl_o.illegal) begin
            ctrl_o.dest     = '0;
            ctrl_o.alu_op   = ALU_ADD;
            ctrl_o.regwrite = 1'b0;
            rs_used_o       = 1'b0;
            rt_used_o       = 1'b0;
        end
        if (ctrl_o.dest == 5'd0) begin
            ctrl_o.regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, writeback bypass, load-use hazard detection and
// the ID/EX pipeline register.
module decode_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_pc,
    output logic [4:0]      rs_addr,
    output logic [4:0]      rt_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_opa,
    output logic [XLEN-1:0] ex_opb,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_shamt,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_dest,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src_imm,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_beq,
    output logic            ex_bne,
    output logic            ex_illegal
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            rs_used;
    logic            rt_used;

    instr_decoder #(.XLEN(XLEN)) u_decoder (
        .instr_i   (id_instr[31:0]),
        .ctrl_o    (dec_ctrl),
        .imm_o     (dec_imm),
        .rs_used_o (rs_used),
        .rt_used_o (rt_used)
    );

    assign rs_addr = dec_ctrl.rs;
    assign rt_addr = dec_ctrl.rt;

    // The regfile returns the old value during a same-cycle write; bypass it.
    logic [XLEN-1:0] opa_fwd;
    logic [XLEN-1:0] opb_fwd;
    assign opa_fwd = (wb_regwrite && wb_rd != 5'd0 && wb_rd == dec_ctrl.rs) ? wb_data : rs_data;
    assign opb_fwd = (wb_regwrite && wb_rd != 5'd0 && wb_rd == dec_ctrl.rt) ? wb_data : rt_data;

    id_ex_t          ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            hazard;

    assign hazard = id_valid && ctrl_q.valid && ctrl_q.ctrl.memread && ctrl_q.ctrl.dest != 5'd0 &&
                    ((rs_used && ctrl_q.ctrl.dest == dec_ctrl.rs) ||
                     (rt_used && ctrl_q.ctrl.dest == dec_ctrl.rt));

    assign id_stall = rst_n && (ex_stall || (hazard && !flush));

    always_comb begin
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        imm_d  = imm_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (ex_stall) begin
            ctrl_d = ctrl_q;
        end else if (hazard) begin
            ctrl_d = '0;
        end else begin
            ctrl_d.valid = id_valid;
            ctrl_d.ctrl  = id_valid ? dec_ctrl : '0;
            pc_d         = id_pc;
            opa_d        = opa_fwd;
            opb_d        = opb_fwd;
            imm_d        = dec_imm;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            pc_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            imm_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= pc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            imm_q  <= imm_d;
        end
    end

    assign ex_valid       = ctrl_q.valid;
    assign ex_pc          = pc_q;
    assign ex_opa         = opa_q;
    assign ex_opb         = opb_q;
    assign ex_imm         = imm_q;
    assign ex_shamt       = ctrl_q.ctrl.shamt;
    assign ex_rs          = ctrl_q.ctrl.rs;
    assign ex_rt          = ctrl_q.ctrl.rt;
    assign ex_dest        = ctrl_q.ctrl.dest;
    assign ex_alu_op      = ctrl_q.ctrl.alu_op;
    assign ex_alu_src_imm = ctrl_q.ctrl.alu_src_imm;
    assign ex_regwrite    = ctrl_q.ctrl.regwrite;
    assign ex_memread     = ctrl_q.ctrl.memread;
    assign ex_memwrite    = ctrl_q.ctrl.memwrite;
    assign ex_beq         = ctrl_q.ctrl.beq;
    assign ex_bne         = ctrl_q.ctrl.bne;
    assign ex_illegal     = ctrl_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_stall;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_opa, ex_opb, ex_imm;
    logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_dest;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src_imm, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_beq, ex_bne, ex_illegal;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADDI5   = 32'h2008_0005;
    localparam logic [31:0] I_ANDI    = 32'h3008_FFFF;
    localparam logic [31:0] I_LUI8000 = 32'h3C08_8000;
    localparam logic [31:0] I_ADDIM1  = 32'h2008_FFFF;
    localparam logic [31:0] I_SLL_RD0 = 32'h0008_0080;
    localparam logic [31:0] I_BADOP   = 32'hFC00_0000;
    localparam logic [31:0] I_ADD     = 32'h010A_4820;
    localparam logic [31:0] I_LW      = 32'h8FA8_0000;
    localparam logic [31:0] I_SLL_T1  = 32'h0008_4880;
    localparam logic [31:0] I_LUI_T0  = 32'h3C08_1234;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_imm(ex_imm),
        .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_illegal(ex_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_valid = 1'b0; id_instr = '0; id_pc = '0;
        rs_data = '0; rt_data = '0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        ex_stall = 1'b0; flush = 1'b0;
        #3;
        checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_pc !== 32'h0 || id_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b regwrite=%b pc=%h id_stall=%b want all 0",
                     ex_valid, ex_regwrite, ex_pc, id_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode_addi();
        issue(I_ADDI5, 32'h0000_0010);
        rs_data = 32'h0;
        #1;
        checks++;
        if (rs_addr !== 5'd0 || rt_addr !== 5'd8) begin
            failures++;
            $display("FAIL addi_rf_addr: rs=%0d rt=%0d want 0 8", rs_addr, rt_addr);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_regwrite !== 1'b1 || ex_dest !== 5'd8 || ex_imm !== 32'h5 ||
            ex_alu_src_imm !== 1'b1 || ex_opa !== 32'h0 || ex_pc !== 32'h10 || ex_alu_op !== 4'd0) begin
            failures++;
            $display("FAIL addi_decode: valid=%b rw=%b dest=%0d imm=%h src=%b opa=%h pc=%h op=%0d",
                     ex_valid, ex_regwrite, ex_dest, ex_imm, ex_alu_src_imm, ex_opa, ex_pc, ex_alu_op);
        end
    endtask

    task automatic test_imm_forms();
        issue(I_ANDI, 32'h14);
        tick();
        checks++;
        if (ex_imm !== 32'h0000_FFFF || ex_alu_op !== 4'd2) begin
            failures++;
            $display("FAIL andi_zext: imm=%h op=%0d want 0000ffff 2", ex_imm, ex_alu_op);
        end
        issue(I_LUI8000, 32'h18);
        tick();
        checks++;
        if (ex_imm !== 32'h8000_0000 || ex_alu_op !== 4'd11) begin
            failures++;
            $display("FAIL lui_imm: imm=%h op=%0d want 80000000 11", ex_imm, ex_alu_op);
        end
        issue(I_ADDIM1, 32'h1C);
        tick();
        checks++;
        if (ex_imm !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL addi_sext: imm=%h want ffffffff", ex_imm);
        end
        issue(I_SLL_RD0, 32'h20);
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_regwrite !== 1'b0 || ex_illegal !== 1'b0 || ex_shamt !== 5'd2 ||
            ex_alu_op !== 4'd8) begin
            failures++;
            $display("FAIL sll_rd0: valid=%b rw=%b ill=%b shamt=%0d op=%0d want 1 0 0 2 8",
                     ex_valid, ex_regwrite, ex_illegal, ex_shamt, ex_alu_op);
        end
        issue(I_BADOP, 32'h24);
        tick();
        checks++;
        if (ex_illegal !== 1'b1 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
            ex_memwrite !== 1'b0 || ex_beq !== 1'b0 || ex_bne !== 1'b0) begin
            failures++;
            $display("FAIL illegal_op: ill=%b rw=%b mr=%b mw=%b beq=%b bne=%b want 1 0 0 0 0 0",
                     ex_illegal, ex_regwrite, ex_memread, ex_memwrite, ex_beq, ex_bne);
        end
        id_valid = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_illegal !== 1'b0) begin
            failures++;
            $display("FAIL idle_bubble: valid=%b rw=%b ill=%b want 0 0 0", ex_valid, ex_regwrite, ex_illegal);
        end
    endtask

    task automatic test_bypass();
        issue(I_ADD, 32'h30);
        rs_data = 32'h0; rt_data = 32'h77;
        wb_regwrite = 1'b1; wb_rd = 5'd8; wb_data = 32'h1234;
        tick();
        checks++;
        if (ex_opa !== 32'h1234 || ex_opb !== 32'h77 || ex_dest !== 5'd9 || ex_rs !== 5'd8 || ex_rt !== 5'd10) begin
            failures++;
            $display("FAIL bypass_rs: opa=%h opb=%h dest=%0d rs=%0d rt=%0d want 1234 77 9 8 10",
                     ex_opa, ex_opb, ex_dest, ex_rs, ex_rt);
        end
        wb_rd = 5'd0;
        tick();
        checks++;
        if (ex_opa !== 32'h0) begin
            failures++;
            $display("FAIL bypass_r0: opa=%h want 0", ex_opa);
        end
        wb_rd = 5'd10;
        tick();
        checks++;
        if (ex_opa !== 32'h0 || ex_opb !== 32'h1234) begin
            failures++;
            $display("FAIL bypass_rt: opa=%h opb=%h want 0 1234", ex_opa, ex_opb);
        end
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; rt_data = 32'h0;
    endtask

    task automatic test_load_use();
        issue(I_LW, 32'h40);
        tick();
        checks++;
        if (ex_memread !== 1'b1 || ex_dest !== 5'd8 || ex_regwrite !== 1'b1) begin
            failures++;
            $display("FAIL lw_decode: mr=%b dest=%0d rw=%b want 1 8 1", ex_memread, ex_dest, ex_regwrite);
        end
        issue(I_ADD, 32'h44);
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_stall: id_stall=%b want 1", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0 || id_stall !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_bubble: valid=%b mr=%b rw=%b id_stall=%b want 0 0 0 0",
                     ex_valid, ex_memread, ex_regwrite, id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_dest !== 5'd9 || ex_pc !== 32'h44) begin
            failures++;
            $display("FAIL loaduse_reissue: valid=%b dest=%0d pc=%h want 1 9 44", ex_valid, ex_dest, ex_pc);
        end
        issue(I_LW, 32'h48);
        tick();
        issue(I_SLL_T1, 32'h4C);
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_sll_rt: id_stall=%b want 1", id_stall);
        end
        issue(I_LUI_T0, 32'h4C);
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_lui_nostall: id_stall=%b want 0", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_imm !== 32'h1234_0000) begin
            failures++;
            $display("FAIL lui_after_lw: valid=%b imm=%h want 1 12340000", ex_valid, ex_imm);
        end
    endtask

    task automatic test_stall_flush();
        issue(I_ADDI5, 32'h60);
        tick();
        issue(I_ANDI, 32'h64);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_stall !== 1'b1) begin
                failures++;
                $display("FAIL stall_id_stall[%0d]: id_stall=%b want 1", i, id_stall);
            end
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_pc !== 32'h60 || ex_imm !== 32'h5 || ex_dest !== 5'd8 ||
                ex_regwrite !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h imm=%h dest=%0d rw=%b want 1 60 5 8 1",
                         i, ex_valid, ex_pc, ex_imm, ex_dest, ex_regwrite);
            end
        end
        flush = 1'b1;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_stall: valid=%b rw=%b want 0 0", ex_valid, ex_regwrite);
        end
        flush = 1'b0; ex_stall = 1'b0;
        issue(I_LW, 32'h70);
        tick();
        issue(I_ADD, 32'h74);
        flush = 1'b1;
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_hazard_stall: id_stall=%b want 0", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL flush_hazard_bubble: valid=%b mr=%b rw=%b want 0 0 0", ex_valid, ex_memread, ex_regwrite);
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        issue(I_ADD, 32'h100);
        rs_data = 32'h55;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_opa !== 32'h55 || ex_pc !== 32'h100) begin
            failures++;
            $display("FAIL pre_reset: valid=%b opa=%h pc=%h want 1 55 100", ex_valid, ex_opa, ex_pc);
        end
        #2;
        rst_n = 1'b0;
        ex_stall = 1'b1;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_opa !== 32'h0 || ex_dest !== 5'd0 ||
            ex_regwrite !== 1'b0 || ex_alu_op !== 4'd0 || ex_rs !== 5'd0 || id_stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b pc=%h opa=%h dest=%0d rw=%b op=%0d rs=%0d id_stall=%b want all 0",
                     ex_valid, ex_pc, ex_opa, ex_dest, ex_regwrite, ex_alu_op, ex_rs, id_stall);
        end
        @(negedge clk);
        ex_stall = 1'b0;
        id_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode_addi();
        test_imm_forms();
        test_bypass();
        test_load_use();
        test_stall_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID pipeline stage of the MIPS core, sitting between the IF/ID register and EX; it is the direct consumer of the register file read ports.
- Decodes the supported MIPS-I integer subset and drives the regfile read addresses.
- Bypasses same-cycle writeback data, because the regfile reads combinationally and writes at the clock edge, so a read during a write returns the old value.
- Detects load-use hazards and registers the decoded operands and controls into the ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath width (the pc, instr, regfile data, wb_data, ex_pc, ex_opa, ex_opb and ex_imm ports are all XLEN wide).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  id_instr/id_pc hold a valid instruction
- id_instr  in  32  instruction word
- id_pc  in  32  PC of id_instr
- rs_addr  out  5  regfile read port 1 address (instr[25:21]), combinational
- rt_addr  out  5  regfile read port 2 address (instr[20:16]), combinational
- rs_data  in  32  regfile readdata1
- rt_data  in  32  regfile readdata2
- wb_regwrite  in  1  writeback write enable (same signal driving regfile regwrite)
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- ex_stall  in  1  EX cannot accept; hold ID/EX
- flush  in  1  branch redirect; squash the instruction in ID
- id_stall  out  1  combinational; upstream must hold IF/ID
- ex_valid, ex_pc[32], ex_opa[32], ex_opb[32], ex_imm[32]  out  ID/EX register
- ex_shamt[5], ex_rs[5], ex_rt[5], ex_dest[5], ex_alu_op[4]  out  ID/EX register
- ex_alu_src_imm, ex_regwrite, ex_memread, ex_memwrite, ex_beq, ex_bne, ex_illegal  out  1 each, ID/EX register

Behaviour:
- Reset: every ex_* output is 0 asynchronously while rst_n=0. id_stall is 0 during reset.
- Latency: one cycle from id_instr to the ex_* outputs.
- Supported instructions: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
- Illegal encodings: any other encoding gives ex_illegal=1 with regwrite, memread, memwrite, beq and bne all 0.
- Destination:
  - R-type: dest = rd.
  - I-type ALU ops and lw: dest = rt.
  - sw, beq, bne: no destination; ex_regwrite=0.
  - ex_regwrite is forced to 0 whenever dest=0.
- Immediate:
  - Sign-extended for addi, addiu, slti, sltiu, lw, sw, beq, bne.
  - Zero-extended for andi, ori, xori.
  - lui gives {imm16, 16'b0}.
  - ex_alu_src_imm=1 for all I-type ALU ops and for lw/sw.
- Register use:
  - rs is used by all supported instructions except sll, srl, sra and lui.
  - rt is used by R-type, sw, beq and bne.
- WB bypass: opa = (wb_regwrite && wb_rd!=0 && wb_rd==rs) ? wb_data : rs_data. opb uses the same rule on rt.
- Load-use hazard: hazard = id_valid && ex_valid && ex_memread && ex_dest!=0 && ((rs used && ex_dest==rs) || (rt used && ex_dest==rt)).
- id_stall = ex_stall || (hazard && !flush).
- ID/EX update, priority order per clock:
  1. flush: load a bubble (ex_valid=0, all controls 0). A flush with ex_stall=1 still bubbles.
  2. ex_stall: hold all ex_* values.
  3. hazard: load a bubble, then re-issue the same ID instruction next cycle once the hazard clears.
  4. otherwise: load the decoded instruction, with ex_valid=id_valid. When id_valid=0, all controls are 0.
- Bubble: ex_pc, ex_opa, ex_opb and ex_imm may hold any value, but every control output is 0.
- ex_rs and ex_rt carry the instruction's rs/rt fields for EX-stage forwarding.

Decomposition:
- Shared package core_pkg holds:
  - opcode_e and funct_e enums.
  - alu_op_t (4-bit enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI).
  - id_ex_t packed struct for the pipeline register.
- One combinational sub-module, instr_decoder: instr in; controls, dest, imm, rs_used and rt_used out.

Test Plan:
- Async reset: drive rst_n=0 mid-stream without a clock edge -> all ex_* outputs read 0 immediately.
- Decode: addi 0x20080005 with id_valid=1 -> next cycle ex_valid=1, ex_regwrite=1, ex_dest=8, ex_imm=5, ex_alu_src_imm=1, ex_opa=0.
- Immediate forms:
  - andi imm 0xFFFF -> ex_imm=0x0000FFFF.
  - lui 0x8000 -> ex_imm=0x80000000.
  - addi imm 0xFFFF -> ex_imm=0xFFFFFFFF.
  - sll with rd=0 -> ex_regwrite=0.
  - opcode 0x3F -> ex_illegal=1.
- WB bypass: add 0x010A4820 with rs_data=0, wb_regwrite=1, wb_rd=8, wb_data=0x1234 -> ex_opa=0x1234. The same case with wb_rd=0 gives ex_opa=0.
- Load-use: lw 0x8FA80000 in EX, then add 0x010A4820 in ID:
  - id_stall=1 and the next cycle has ex_valid=0.
  - The cycle after, the add issues with ex_valid=1.
  - The same test with sll $t1,$t0,2 (rt=8 used) also stalls. lui $t0 with rt=8 unused does not stall.
- Stall/flush:
  - ex_stall=1 for 3 cycles -> ex_* outputs unchanged and id_stall=1.
  - flush=1 together with ex_stall=1 -> ex_valid=0 next cycle.
  - flush during a load-use hazard -> bubble and id_stall=0.
